// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard unit and its
// HI/LO multiply/divide occupancy timer.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;
    localparam int MD_CNT_W    = 6;

endpackage

// File: rtl/md_timer.sv
// HI/LO unit occupancy timer: IDLE/BUSY machine with a down-counter that
// pulses done in the final busy cycle.
module md_timer
    import pipeline_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    localparam logic [MD_CNT_W-1:0] MUL_LOAD = MD_CNT_W'(MUL_LAT - 1);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD = MD_CNT_W'(DIV_LAT - 1);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   count_q, count_d;
    logic [MD_CNT_W-1:0]   load_val;

    assign load_val = is_div ? DIV_LOAD : MUL_LOAD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // A start in the done cycle reloads so back-to-back ops keep busy high.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    count_d = load_val;
                end
            end
            BUSY: begin
                if (count_q == '0) begin
                    done = 1'b1;
                    if (start) begin
                        count_d = load_val;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign busy = (state_q == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use/branch/HI-LO stalls,
// and decode/execute flush control.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic       branch_d,
    input  logic       pc_src_d,
    input  logic       jump_d,
    input  logic       md_op_d,
    input  logic       hilo_read_d,
    input  logic [4:0] rs_e,
    input  logic [4:0] rt_e,
    input  logic [4:0] write_reg_e,
    input  logic       reg_write_e,
    input  logic       mem_to_reg_e,
    input  logic       md_start_e,
    input  logic       md_div_e,
    input  logic [4:0] write_reg_m,
    input  logic       reg_write_m,
    input  logic       mem_to_reg_m,
    input  logic [4:0] write_reg_w,
    input  logic       reg_write_w,
    output logic       stall_f,
    output logic       stall_d,
    output logic       flush_d,
    output logic       flush_e,
    output logic       fwd_a_d,
    output logic       fwd_b_d,
    output logic [1:0] fwd_a_e,
    output logic [1:0] fwd_b_e,
    output logic       md_busy,
    output logic       md_done
);

    logic     lw_stall, br_stall, hilo_stall, stall;
    logic     m_valid, w_valid, e_valid, m_load;
    fwd_sel_e sel_a, sel_b;

    md_timer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start_e),
        .is_div (md_div_e),
        .busy   (md_busy),
        .done   (md_done)
    );

    assign m_valid = reg_write_m && (write_reg_m != 5'd0);
    assign w_valid = reg_write_w && (write_reg_w != 5'd0);
    assign e_valid = reg_write_e && (write_reg_e != 5'd0);
    assign m_load  = mem_to_reg_m && (write_reg_m != 5'd0);

    // Memory stage holds the younger result, so it wins over writeback.
    always_comb begin
        sel_a = FWD_RF;
        sel_b = FWD_RF;
        if (m_valid && (write_reg_m == rs_e))      sel_a = FWD_MEM;
        else if (w_valid && (write_reg_w == rs_e)) sel_a = FWD_WB;
        if (m_valid && (write_reg_m == rt_e))      sel_b = FWD_MEM;
        else if (w_valid && (write_reg_w == rt_e)) sel_b = FWD_WB;
    end

    assign fwd_a_e = sel_a;
    assign fwd_b_e = sel_b;

    assign fwd_a_d = (rs_d != 5'd0) && (rs_d == write_reg_m) && reg_write_m;
    assign fwd_b_d = (rt_d != 5'd0) && (rt_d == write_reg_m) && reg_write_m;

    assign lw_stall = mem_to_reg_e && (rt_e != 5'd0) &&
                      ((rt_e == rs_d) || (rt_e == rt_d));

    assign br_stall = branch_d &&
                      ((e_valid && ((write_reg_e == rs_d) || (write_reg_e == rt_d))) ||
                       (m_load  && ((write_reg_m == rs_d) || (write_reg_m == rt_d))));

    // Include md_start_e so an op entering execute blocks decode immediately.
    assign hilo_stall = (md_busy || md_start_e) && (md_op_d || hilo_read_d);

    assign stall   = lw_stall || br_stall || hilo_stall;
    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;
    assign flush_d = (pc_src_d || jump_d) && !stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, stall/flush priority and the
// HI/LO timer including restart and asynchronous reset mid-operation.
module tb_hazard_ctrl;

    logic       clk, rst;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
    logic       branch_d, pc_src_d, jump_d, md_op_d, hilo_read_d;
    logic       reg_write_e, mem_to_reg_e, md_start_e, md_div_e;
    logic       reg_write_m, mem_to_reg_m, reg_write_w;
    logic       stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       md_busy, md_done;

    int tests_run = 0;
    int tests_failed = 0;

    hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32)) dut (
        .clk(clk), .rst(rst),
        .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d), .pc_src_d(pc_src_d),
        .jump_d(jump_d), .md_op_d(md_op_d), .hilo_read_d(hilo_read_d),
        .rs_e(rs_e), .rt_e(rt_e), .write_reg_e(write_reg_e),
        .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
        .md_start_e(md_start_e), .md_div_e(md_div_e),
        .write_reg_m(write_reg_m), .reg_write_m(reg_write_m),
        .mem_to_reg_m(mem_to_reg_m), .write_reg_w(write_reg_w),
        .reg_write_w(reg_write_w),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .md_busy(md_busy), .md_done(md_done)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
        branch_d = 0; pc_src_d = 0; jump_d = 0; md_op_d = 0; hilo_read_d = 0;
        reg_write_e = 0; mem_to_reg_e = 0; md_start_e = 0; md_div_e = 0;
        reg_write_m = 0; mem_to_reg_m = 0; reg_write_w = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #2;
        tests_run++;
        if (md_busy !== 1'b0 || md_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_timer: busy=%b done=%b expected 0 0", md_busy, md_done);
        end
        tests_run++;
        if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_stalls: got %b expected 0000", {stall_f, stall_d, flush_d, flush_e});
        end
        tick(); tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fwd_e();
        clear_inputs();
        write_reg_m = 5; reg_write_m = 1; write_reg_w = 5; reg_write_w = 1; rs_e = 5; rt_e = 5;
        #1;
        tests_run++;
        if (fwd_a_e !== 2'b10 || fwd_b_e !== 2'b10) begin
            tests_failed++;
            $display("FAIL fwd_e_mem_prio: a=%b b=%b expected 10 10", fwd_a_e, fwd_b_e);
        end
        write_reg_m = 0;
        #1;
        tests_run++;
        if (fwd_a_e !== 2'b01 || fwd_b_e !== 2'b01) begin
            tests_failed++;
            $display("FAIL fwd_e_wb: a=%b b=%b expected 01 01", fwd_a_e, fwd_b_e);
        end
        write_reg_m = 9; rt_e = 9; reg_write_w = 0;
        #1;
        tests_run++;
        if (fwd_a_e !== 2'b00 || fwd_b_e !== 2'b10) begin
            tests_failed++;
            $display("FAIL fwd_e_split: a=%b b=%b expected 00 10", fwd_a_e, fwd_b_e);
        end
        reg_write_w = 1; write_reg_w = 0; rs_e = 0; reg_write_m = 0;
        #1;
        tests_run++;
        if (fwd_a_e !== 2'b00 || fwd_b_e !== 2'b00) begin
            tests_failed++;
            $display("FAIL fwd_e_r0: a=%b b=%b expected 00 00", fwd_a_e, fwd_b_e);
        end
    endtask

    task automatic test_fwd_d();
        clear_inputs();
        rs_d = 7; rt_d = 3; write_reg_m = 7; reg_write_m = 1;
        #1;
        tests_run++;
        if (fwd_a_d !== 1'b1 || fwd_b_d !== 1'b0) begin
            tests_failed++;
            $display("FAIL fwd_d_rs: a=%b b=%b expected 1 0", fwd_a_d, fwd_b_d);
        end
        rs_d = 0; rt_d = 0; write_reg_m = 0;
        #1;
        tests_run++;
        if (fwd_a_d !== 1'b0 || fwd_b_d !== 1'b0) begin
            tests_failed++;
            $display("FAIL fwd_d_r0: a=%b b=%b expected 0 0", fwd_a_d, fwd_b_d);
        end
        rt_d = 12; write_reg_m = 12; reg_write_m = 0;
        #1;
        tests_run++;
        if (fwd_b_d !== 1'b0) begin
            tests_failed++;
            $display("FAIL fwd_d_nowrite: b=%b expected 0", fwd_b_d);
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        mem_to_reg_e = 1; rt_e = 8; rs_d = 8;
        #1;
        tests_run++;
        if ({stall_f, stall_d, flush_e, flush_d} !== 4'b1110) begin
            tests_failed++;
            $display("FAIL load_use_rs: sf,sd,fe,fd=%b expected 1110", {stall_f, stall_d, flush_e, flush_d});
        end
        rs_d = 1; rt_d = 8;
        #1;
        tests_run++;
        if (stall_d !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_use_rt: stall_d=%b expected 1", stall_d);
        end
        rt_e = 0; rs_d = 0; rt_d = 0;
        #1;
        tests_run++;
        if (stall_d !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_use_r0: stall_d=%b expected 0", stall_d);
        end
    endtask

    task automatic test_branch_stall();
        clear_inputs();
        branch_d = 1; reg_write_e = 1; write_reg_e = 3; rt_d = 3;
        #1;
        tests_run++;
        if (stall_d !== 1'b1) begin
            tests_failed++;
            $display("FAIL branch_e: stall_d=%b expected 1", stall_d);
        end
        reg_write_e = 0; mem_to_reg_m = 1; write_reg_m = 4; rs_d = 4;
        #1;
        tests_run++;
        if (stall_d !== 1'b1) begin
            tests_failed++;
            $display("FAIL branch_m: stall_d=%b expected 1", stall_d);
        end
        branch_d = 0;
        #1;
        tests_run++;
        if (stall_d !== 1'b0) begin
            tests_failed++;
            $display("FAIL branch_none: stall_d=%b expected 0", stall_d);
        end
        branch_d = 1; mem_to_reg_m = 0; reg_write_m = 1;
        #1;
        tests_run++;
        if (stall_d !== 1'b0) begin
            tests_failed++;
            $display("FAIL branch_alu_m: stall_d=%b expected 0", stall_d);
        end
    endtask

    task automatic test_flush_priority();
        clear_inputs();
        pc_src_d = 1; branch_d = 1; mem_to_reg_e = 1; rt_e = 8; rs_d = 8;
        #1;
        tests_run++;
        if (flush_d !== 1'b0 || stall_d !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_suppressed: flush_d=%b stall_d=%b expected 0 1", flush_d, stall_d);
        end
        tick();
        mem_to_reg_e = 0;
        #1;
        tests_run++;
        if (flush_d !== 1'b1 || stall_d !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_taken: flush_d=%b stall_d=%b expected 1 0", flush_d, stall_d);
        end
        pc_src_d = 0; branch_d = 0; jump_d = 1;
        #1;
        tests_run++;
        if (flush_d !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_jump: flush_d=%b expected 1", flush_d);
        end
    endtask

    task automatic test_div();
        clear_inputs();
        md_start_e = 1; md_div_e = 1; hilo_read_d = 1;
        #1;
        tests_run++;
        if (stall_d !== 1'b1 || md_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL div_start: stall_d=%b busy=%b expected 1 0", stall_d, md_busy);
        end
        tick();
        md_start_e = 0; md_div_e = 0;
        for (int i = 1; i <= 32; i++) begin
            #1;
            tests_run++;
            if (md_busy !== 1'b1 || stall_d !== 1'b1 || md_done !== (i == 32)) begin
                tests_failed++;
                $display("FAIL div_cycle%0d: busy=%b stall_d=%b done=%b expected 1 1 %b",
                         i, md_busy, stall_d, md_done, (i == 32));
            end
            tick();
        end
        #1;
        tests_run++;
        if (md_busy !== 1'b0 || md_done !== 1'b0 || stall_d !== 1'b0) begin
            tests_failed++;
            $display("FAIL div_end: busy=%b done=%b stall_d=%b expected 0 0 0", md_busy, md_done, stall_d);
        end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        md_start_e = 1;
        tick();
        md_start_e = 0;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) md_start_e = 1;
            #1;
            tests_run++;
            if (md_busy !== 1'b1 || md_done !== (i == 4)) begin
                tests_failed++;
                $display("FAIL mul1_cycle%0d: busy=%b done=%b expected 1 %b", i, md_busy, md_done, (i == 4));
            end
            tick();
        end
        md_start_e = 0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            tests_run++;
            if (md_busy !== 1'b1 || md_done !== (i == 4)) begin
                tests_failed++;
                $display("FAIL mul2_cycle%0d: busy=%b done=%b expected 1 %b", i, md_busy, md_done, (i == 4));
            end
            tick();
        end
        #1;
        tests_run++;
        if (md_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mul2_end: busy=%b expected 0", md_busy);
        end
    endtask

    task automatic test_reset_mid_div();
        clear_inputs();
        md_start_e = 1; md_div_e = 1;
        tick();
        md_start_e = 0; md_div_e = 0;
        // Counter is 31 now; 14 more edges bring it to 17.
        repeat (14) tick();
        hilo_read_d = 1;
        #1;
        tests_run++;
        if (md_busy !== 1'b1 || stall_d !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre: busy=%b stall_d=%b expected 1 1", md_busy, stall_d);
        end
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if (md_busy !== 1'b0 || md_done !== 1'b0 || stall_d !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_async: busy=%b done=%b stall_d=%b expected 0 0 0", md_busy, md_done, stall_d);
        end
        md_op_d = 1; md_start_e = 1;
        #1;
        tests_run++;
        if (stall_d !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_comb_follow: stall_d=%b expected 1", stall_d);
        end
        md_start_e = 0; md_op_d = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests_run++;
            if (md_done !== 1'b0 || md_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_hold%0d: busy=%b done=%b expected 0 0", i, md_busy, md_done);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        tests_run++;
        if (md_busy !== 1'b0 || stall_d !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_release: busy=%b stall_d=%b expected 0 0", md_busy, stall_d);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_fwd_e();
        test_fwd_d();
        test_load_use();
        test_branch_stall();
        test_flush_priority();
        test_div();
        test_back_to_back();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
